// File: rtl/rca_pkg.sv
// Shared constants for the nibble-serial adder: FSM encodings and the width
// of the reused 4-bit ripple-carry adder.
package rca_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

endpackage

// File: rtl/ripple_carry_adder.sv
// Existing 4-bit ripple-carry adder, purely combinational.
module ripple_carry_adder
  import rca_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic carry;

  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/rca_word_sequencer.sv
// Word-wide adder built by stepping one 4-bit ripple-carry adder over the
// operand nibbles, LSB first, with the carry registered between steps.
module rca_word_sequencer
  import rca_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              busy
);

  localparam int NUM_NIB = WORD_W / NIB_W;
  localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

  logic [1:0]        state;
  logic [IDX_W-1:0]  nib_idx;
  logic              carry_q;
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;

  logic [NIB_W-1:0]  add_a;
  logic [NIB_W-1:0]  add_b;
  logic [NIB_W-1:0]  add_s;
  logic              add_co;
  logic              last_nib;

  assign add_a    = a_q[nib_idx*NIB_W +: NIB_W];
  assign add_b    = b_q[nib_idx*NIB_W +: NIB_W];
  assign last_nib = (nib_idx == IDX_W'(NUM_NIB - 1));

  ripple_carry_adder u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  // Handshake flags decode from state alone; in_ready is also held low during reset.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state == ADD) || (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      nib_idx <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            nib_idx <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            state   <= ADD;
          end
        end
        ADD: begin
          sum[nib_idx*NIB_W +: NIB_W] <= add_s;
          carry_q                     <= add_co;
          if (last_nib) begin
            cout  <= add_co;
            state <= HOLD;
          end else begin
            nib_idx <= nib_idx + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state   <= IDLE;
            nib_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed self-checking bench for rca_word_sequencer (WORD_W=16) with a
// result scoreboard filled at issue time and drained on each output handshake.
module tb_rca_word_sequencer;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
  } result_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int passCount  = 0;
  int checkCount = 0;
  result_t expQ[$];

  rca_word_sequencer #(.WORD_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Advance to just after the next rising edge so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation in IDLE for one accept edge and record its golden result.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic cv);
    logic [16:0] full;
    checkOutput("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    full     = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    expQ.push_back('{sum: full[15:0], cout: full[16]});
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; measures latency and in_ready during the op.
  task automatic waitResult(input logic release_out);
    int cyc = 0;
    int rdyHigh = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      if (in_ready !== 1'b0) rdyHigh++;
      tick();
      cyc++;
    end
    checkOutput("out_valid_seen", {31'd0, out_valid}, 32'd1);
    checkOutput("latency", cyc, 32'd4);
    if (in_ready !== 1'b0) rdyHigh++;
    checkOutput("in_ready_low_while_busy", rdyHigh, 32'd0);
    checkOutput("busy_in_hold", {31'd0, busy}, 32'd1);
    if (release_out) begin
      tick();
      checkOutput("in_ready_after_hold", {31'd0, in_ready}, 32'd1);
      checkOutput("busy_after_hold", {31'd0, busy}, 32'd0);
    end
  endtask

  // Scoreboard drain: every completed handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = expQ.pop_front();
        checkOutput("sb_sum", {16'd0, sum}, {16'd0, e.sum});
        checkOutput("sb_cout", {31'd0, cout}, {31'd0, e.cout});
      end
    end
  end

  initial begin
    int cyc;
    int seen;
    logic acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 16'hDEAD;
    b         = 16'hBEEF;
    cin       = 1'b1;
    tick();
    tick();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_sum", {16'd0, sum}, 32'd0);
    checkOutput("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] basic add");
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    waitResult(1'b1);

    $display("[TB] carry propagation");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    waitResult(1'b1);
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    waitResult(1'b1);
    applyStimulus(16'h8000, 16'h8000, 1'b1);
    waitResult(1'b1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(16'h00F0, 16'h0F10, 1'b0);
    waitResult(1'b0);
    for (int i = 0; i < 6; i++) begin
      a        = 16'h5A5A + 16'(i);
      b        = 16'hA5A5;
      in_valid = 1'b1;
      tick();
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_sum", {16'd0, sum}, 32'h1000);
      checkOutput("bp_cout", {31'd0, cout}, 32'd0);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_sb_drained", expQ.size(), 32'd0);

    $display("[TB] reset abort");
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready_forced", {31'd0, in_ready}, 32'd0);
    tick();
    void'(expQ.pop_back());
    checkOutput("abort_sum", {16'd0, sum}, 32'd0);
    checkOutput("abort_cout", {31'd0, cout}, 32'd0);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checkOutput("abort_no_result", seen, 32'd0);
    applyStimulus(16'h00A5, 16'h005A, 1'b0);
    waitResult(1'b1);

    $display("[TB] back-to-back");
    a        = 16'h0001;
    b        = 16'h0001;
    cin      = 1'b0;
    in_valid = 1'b1;
    expQ.push_back('{sum: 16'h0002, cout: 1'b0});
    tick();
    a = 16'h7FFF;
    b = 16'h0001;
    expQ.push_back('{sum: 16'h8000, cout: 1'b0});
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 30) begin
      acc = in_ready;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("issue_interval", cyc, 32'd6);
    waitResult(1'b1);

    tick();
    checkOutput("sb_empty", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rca_word_sequencer.md
Name: rca_word_sequencer

Overview:
Adds two WORD_W-bit operands by running one 4-bit ripple_carry_adder instance over successive nibbles, LSB nibble first. The carry is held in a register between nibbles. Operands come in through a valid/ready input handshake and results leave through a valid/ready output handshake. This lets wide additions reuse the team's existing 4-bit adder instead of a WORD_W-wide carry chain.

Parameters:
WORD_W, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
NUM_NIB, WORD_W/4, derived: number of nibble steps per addition (not overridable).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous and active-low
in_valid  input  1  operands on a/b/cin are valid
in_ready  output  1  block can accept an operation
a  input  WORD_W  operand A
b  input  WORD_W  operand B
cin  input  1  carry-in to LSB nibble
out_valid  output  1  sum/cout hold a completed result
out_ready  input  1  consumer accepts result
sum  output  WORD_W  registered result, modulo 2^WORD_W
cout  output  1  registered carry out of MSB nibble
busy  output  1  high in ADD or HOLD

Behaviour:
- Reset (rst_n sampled low at a rising edge):
  - state=IDLE, nib_idx=0, carry_q=0, a_q=b_q=0, sum=0, cout=0.
  - out_valid=0 and busy=0.
  - in_ready is forced 0 while rst_n is low.
- in_ready, out_valid and busy decode from state only; they have no combinational path from in_valid or out_ready.
- State IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid=1 at an edge: capture a_q<=a, b_q<=b, carry_q<=cin, nib_idx<=0, sum<=0, cout<=0; go to ADD.
- State ADD:
  - in_ready=0, busy=1.
  - The adder sees a_q/b_q nibble [4*nib_idx+3:4*nib_idx] and carry_q.
  - Each edge writes the adder sum into the same nibble of sum and sets carry_q<=adder cout.
  - If nib_idx==NUM_NIB-1: cout<=adder cout; go to HOLD. Otherwise nib_idx<=nib_idx+1.
  - Exactly NUM_NIB cycles in ADD.
- State HOLD:
  - out_valid=1, busy=1, in_ready=0.
  - sum and cout are stable.
  - On out_ready=1 at an edge: go to IDLE, nib_idx<=0. sum and cout keep their value until the next accept.
- Latency: accept edge E0, nibble k written at edge E(k+1), out_valid high in the cycle after edge E(NUM_NIB).
  - That is NUM_NIB cycles from accept to out_valid.
  - Minimum issue interval is NUM_NIB+2 cycles (ADD, HOLD with out_ready=1, IDLE).
- Input changes on a/b/cin while busy have no effect, because operands are captured.
- in_valid while busy is ignored: no queueing, and the transaction is not lost by the block because in_ready=0.
- out_ready outside HOLD is ignored.
- Arithmetic is unsigned modulo 2^WORD_W; overflow is visible only through cout.
- WORD_W=4 degenerates to a single ADD cycle.
- Reset mid-operation (ADD or HOLD) aborts:
  - no out_valid is produced for the aborted operation;
  - all registers return to reset values at that edge.

Decomposition:
- Shared package (rca_pkg):
  - state enum {IDLE, ADD, HOLD} as 2-bit;
  - constant NIB_W=4, the width of ripple_carry_adder.
- One sub-module: a single existing ripple_carry_adder instance (a, b, cin, s, cout), 4-bit, purely combinational.
- nib_idx width is $clog2(NUM_NIB), minimum 1.

Test Plan:
(WORD_W=16, out_ready=1 unless stated)
1. a=0x1234, b=0x4321, cin=0 accepted -> out_valid exactly 4 cycles after accept edge, sum=0x5555, cout=0; in_ready=0 for the 5 cycles from ADD entry through HOLD.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry propagates through all 4 nibbles.
3. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1.
4. Backpressure on a=0x00F0, b=0x0F10, cin=0:
   - hold out_ready=0 for 6 cycles -> out_valid stays 1, sum=0x1000, cout=0 stable;
   - meanwhile change a/b and pulse in_valid -> ignored, in_ready=0;
   - raise out_ready -> in_ready=1 next cycle.
5. Reset abort:
   - drive rst_n=0 during the 2nd ADD cycle of 0x1111+0x2222 -> next edge sum=0, cout=0, out_valid=0, busy=0, and no result ever appears;
   - after release, 0x00A5+0x005A, cin=0 -> sum=0x00FF, cout=0.
6. Back-to-back, in_valid held high: 0x0001+0x0001 then 0x7FFF+0x0001 -> results 0x0002/cout=0 then 0x8000/cout=0, issued 6 cycles apart.
